// File: rtl/sha256_msg_padder.sv
// SHA-256 message front end: packs 32-bit big-endian words into 512-bit blocks,
// applies the 0x80 / zero-fill / bit-length trailer and sequences the compression core.
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [255:0] core_H_in,
  output logic [511:0] core_M_in,
  output logic         core_input_valid,
  input  logic [255:0] core_H_out,
  input  logic         core_output_valid,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {FILL, PAD, SEND, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [511:0]       blk, pad_blk;
  logic [3:0]         widx;
  logic [LEN_W-1:0]   byte_cnt;
  logic [255:0]       chain;
  logic               first, final_blk, pad_pending, trail80, full, msg_act;
  logic               accept, put_len;
  logic [5:0]         off;
  logic [63:0]        bit_len;

  assign accept           = in_valid && in_ready;
  assign off              = byte_cnt[5:0];
  assign bit_len          = 64'(byte_cnt) << 3;
  assign core_M_in        = blk;
  assign core_H_in        = first ? IV : chain;
  assign busy             = msg_act;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    in_ready         = 1'b0;
    core_input_valid = 1'b0;
    digest_valid     = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)            state_nxt = PAD;
          else if (widx == 4'd15) state_nxt = SEND;
        end
      end
      PAD:  state_nxt = SEND;
      SEND: begin
        core_input_valid = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (core_output_valid) begin
          if (final_blk)        state_nxt = DONE;
          else if (pad_pending) state_nxt = PAD;
          else                  state_nxt = FILL;
        end
      end
      DONE: begin
        digest_valid = 1'b1;
        state_nxt    = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Trailer build. A block that ended exactly full is sent untouched and the
  // 0x80 moves to byte 0 of the follow-on block (trail80).
  always_comb begin
    put_len = pad_pending || (!full && off <= 6'd55);
    pad_blk = blk;
    if (pad_pending) begin
      if (trail80) pad_blk[511:504] = 8'h80;
    end else if (!full) begin
      for (int i = 0; i < 64; i++) begin
        if (i == int'(off))     pad_blk[511-8*i -: 8] = 8'h80;
        else if (i > int'(off)) pad_blk[511-8*i -: 8] = 8'h00;
      end
    end
    if (put_len) pad_blk[63:0] = bit_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk         <= '0;
      widx        <= '0;
      byte_cnt    <= '0;
      chain       <= '0;
      digest      <= '0;
      first       <= 1'b1;
      final_blk   <= 1'b0;
      pad_pending <= 1'b0;
      trail80     <= 1'b0;
      full        <= 1'b0;
      msg_act     <= 1'b0;
    end else begin
      case (state)
        FILL: if (accept) begin
          for (int w = 0; w < 16; w++)
            if (widx == 4'(w)) blk[511-32*w -: 32] <= in_data;
          widx     <= widx + 4'd1;
          byte_cnt <= byte_cnt + (in_last ? LEN_W'(in_nbytes) : LEN_W'(3'd4));
          full     <= in_last && (widx == 4'd15) && (in_nbytes == 3'd4);
          msg_act  <= 1'b1;
        end
        PAD: begin
          blk         <= pad_blk;
          final_blk   <= put_len;
          pad_pending <= !put_len;
          if (!pad_pending) trail80 <= full;
        end
        WAIT: if (core_output_valid) begin
          chain <= core_H_out;
          first <= 1'b0;
          if (final_blk) begin
            digest  <= core_H_out;
            msg_act <= 1'b0;
          end else begin
            // final block stays on core_M_in; others make room for the next one
            blk <= '0;
            if (!pad_pending) widx <= '0;
          end
        end
        DONE: begin
          byte_cnt    <= '0;
          widx        <= '0;
          first       <= 1'b1;
          final_blk   <= 1'b0;
          pad_pending <= 1'b0;
          trail80     <= 1'b0;
          full        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: emulates the compression core and checks blocks,
// chaining and digests against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, in_last = 0;
  logic [31:0]  in_data = 0;
  logic [2:0]   in_nbytes = 0;
  logic         in_ready, core_input_valid, digest_valid, busy;
  logic [255:0] core_H_in, digest;
  logic [511:0] core_M_in;
  logic [255:0] core_H_out = 0;
  logic         core_output_valid = 0;

  int total = 0, bad = 0;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_msg_padder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .core_H_in(core_H_in), .core_M_in(core_M_in), .core_input_valid(core_input_valid),
    .core_H_out(core_H_out), .core_output_valid(core_output_valid),
    .digest(digest), .digest_valid(digest_valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // core emulator and digest monitor
  logic [511:0] obs_M [$];
  logic [255:0] obs_H [$];
  logic [255:0] obs_D [$];
  int lat_fix = 0;
  bit core_busy = 0, aborted = 0;

  initial begin : core_emu
    logic [511:0] m;
    logic [255:0] h;
    int n;
    forever begin
      @(negedge clk);
      if (core_input_valid && rst_n) begin
        core_busy = 1;
        m = core_M_in; h = core_H_in;
        obs_M.push_back(m); obs_H.push_back(h);
        n = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
        repeat (n) @(negedge clk);
        if (!aborted) begin
          chk("hold_M", core_M_in, m);
          chk("hold_H", core_H_in, h);
        end
        core_H_out = sha_compress(h, m);
        core_output_valid = 1;
        @(negedge clk);
        core_output_valid = 0;
        core_busy = 0;
      end
    end
  end

  always @(negedge clk) if (digest_valid) obs_D.push_back(digest);

  // reference model: byte-level padding, block split, chaining
  logic [511:0] exp_M [$];
  logic [255:0] exp_H [$];
  logic [255:0] exp_D;

  task automatic build_exp(input byte unsigned msg[$]);
    byte unsigned p[$];
    logic [63:0] bl;
    logic [255:0] h;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_M.delete(); exp_H.delete();
    h = IV;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      exp_M.push_back(b); exp_H.push_back(h);
      h = sha_compress(h, b);
    end
    exp_D = h;
  endtask

  // drives at negedges; in_ready seen at a negedge is the value at the next posedge
  task automatic send_msg(input byte unsigned msg[$], input bit extra, input bit gaps, output int nacc);
    logic [31:0] wd [$];
    logic        wl [$];
    logic [2:0]  wn [$];
    int L, nb, cyc;
    logic [31:0] d;
    L = msg.size();
    for (int i = 0; i < L; i += 4) begin
      nb = (L - i >= 4) ? 4 : L - i;
      d = $urandom;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg[i+b];
      wd.push_back(d); wn.push_back(3'(nb));
      wl.push_back((i + 4 >= L) && !extra);
    end
    if (L == 0 || extra) begin
      wd.push_back($urandom); wn.push_back(3'd0); wl.push_back(1'b1);
    end
    nacc = 0;
    for (int k = 0; k < wd.size(); k++) begin
      if (gaps) begin
        in_valid = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1; in_data = wd[k]; in_last = wl[k]; in_nbytes = wn[k];
      cyc = 0;
      while (!in_ready && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      if (!in_ready) begin
        chk("accept_timeout", cyc, 0);
        in_valid = 0;
        return;
      end
      nacc++;
      @(negedge clk);
      if (k == 0) chk("busy_on", busy, 1);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic run_msg(input string tag, input byte unsigned msg[$], input bit allow_extra,
                         input bit gaps, input bit known, input logic [255:0] kdig);
    int nacc, cyc, nw;
    bit extra;
    build_exp(msg);
    obs_M.delete(); obs_H.delete(); obs_D.delete();
    extra = (allow_extra && msg.size() > 0 && msg.size() % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4 + int'(extra);
    send_msg(msg, extra, gaps, nacc);
    chk({tag, ":words"}, nacc, nw);
    cyc = 0;
    while (obs_D.size() == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":dv"}, obs_D.size(), 1);
    repeat (3) @(negedge clk);
    chk({tag, ":nblk"}, obs_M.size(), exp_M.size());
    for (int k = 0; k < obs_M.size() && k < exp_M.size(); k++) begin
      chk($sformatf("%s:M%0d", tag, k), obs_M[k], exp_M[k]);
      chk($sformatf("%s:H%0d", tag, k), obs_H[k], exp_H[k]);
    end
    if (obs_D.size() > 0) begin
      chk({tag, ":digest"}, obs_D[0], exp_D);
      if (known) chk({tag, ":known"}, obs_D[0], kdig);
    end
    chk({tag, ":ndv"}, obs_D.size(), 1);
    chk({tag, ":busy_off"}, busy, 0);
    chk({tag, ":ready"}, in_ready, 1);
  endtask

  function automatic void str2q(input string s, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  function automatic void rndq(input int n, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin : main
    byte unsigned q[$];
    int cyc;
    int blens [8] = '{55, 56, 63, 65, 120, 128, 4, 60};

    repeat (3) @(negedge clk);
    chk("rst:ready", in_ready, 1);
    chk("rst:civ", core_input_valid, 0);
    chk("rst:dv", digest_valid, 0);
    chk("rst:busy", busy, 0);
    chk("rst:digest", digest, 0);
    chk("rst:M", core_M_in, 0);
    chk("rst:H", core_H_in, IV);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst:ready", in_ready, 1);

    str2q("abc", q);
    run_msg("abc", q, 0, 0, 1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    q.delete();
    run_msg("empty", q, 0, 0, 1, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", q);
    run_msg("abc56", q, 0, 0, 1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    rndq(64, q);  run_msg("len64", q, 0, 0, 0, '0);
    rndq(119, q); run_msg("len119", q, 0, 1, 0, '0);
    rndq(100, q); run_msg("bp100", q, 0, 0, 0, '0);

    foreach (blens[i]) begin
      rndq(blens[i], q);
      run_msg($sformatf("bnd%0d", blens[i]), q, 1, 1, 0, '0);
    end
    for (int i = 0; i < 10; i++) begin
      rndq($urandom_range(0, 200), q);
      run_msg($sformatf("rnd%0d_len%0d", i, q.size()), q, 1, i % 2, 0, '0);
    end

    // abort a message while the core is busy
    obs_M.delete(); obs_D.delete();
    aborted = 1; lat_fix = 8;
    begin
      int nacc;
      rndq(20, q);
      send_msg(q, 0, 0, nacc);
    end
    cyc = 0;
    while (obs_M.size() == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort:sent", obs_M.size(), 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort:digest_clr", digest, 0);
    chk("abort:busy", busy, 0);
    chk("abort:H", core_H_in, IV);
    chk("abort:M", core_M_in, 0);
    cyc = 0;
    while (core_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("abort:no_dv", obs_D.size(), 0);
    aborted = 0; lat_fix = 0;
    str2q("abc", q);
    run_msg("abc_after_abort", q, 0, 0, 1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
